// File: rtl/rr_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_port_arbiter_if
// Purpose  : N-producer / 1-consumer valid-ready bundle for rr_port_arbiter.
// Revision : 1.0
// ============================================================================
interface rr_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_WIDTH = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS-1:0]            in_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]            in_last;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_last;
  logic [ID_WIDTH-1:0]             out_id;
  logic [15:0]                     beat_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_id, beat_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_id, beat_count
  );
endinterface
`default_nettype wire

// File: rtl/rr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_port_arbiter
// Purpose  : Round-robin N:1 stream arbiter, registered output, packet lock.
// Revision : 1.0
// ============================================================================
module rr_port_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int PACKET_MODE = 0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  rr_port_arbiter_if.slave   bus
);
  localparam int ID_WIDTH = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_WIDTH-1:0]   r_lock_id;
  logic [ID_WIDTH-1:0]   w_lock_id_nxt;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   w_ptr_nxt;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic [ID_WIDTH-1:0]   r_out_id;
  logic [15:0]           r_beat_count;

  logic                  w_load_en;
  logic                  w_grant_valid;
  logic [ID_WIDTH-1:0]   w_grant;
  logic [ID_WIDTH-1:0]   w_grant_inc;
  logic [NUM_PORTS-1:0]  w_in_ready;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;

  assign w_load_en = !r_out_valid || bus.out_ready;

  // Descending scan so the port closest to r_ptr is the last (winning) write.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    if (r_state == ST_LOCKED) begin
      w_grant_valid = 1'b1;
      w_grant       = r_lock_id;
    end else begin
      for (int j = NUM_PORTS - 1; j >= 0; j--) begin
        if (bus.in_valid[(int'(r_ptr) + j) % NUM_PORTS]) begin
          w_grant_valid = 1'b1;
          w_grant       = ID_WIDTH'((int'(r_ptr) + j) % NUM_PORTS);
        end
      end
    end
  end

  // Gated by rst so nothing is handshaken while the output stage is cleared.
  assign w_in_ready  = (!rst && w_load_en && w_grant_valid) ?
                       (NUM_PORTS'(1) << w_grant) : '0;
  assign w_accept    = |(bus.in_valid & w_in_ready);
  assign w_sel_data  = bus.in_data[w_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_last  = bus.in_last[w_grant];
  assign w_grant_inc = (w_grant == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : w_grant + ID_WIDTH'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_ptr_nxt     = r_ptr;
    if (w_accept) begin
      if (PACKET_MODE == 0) begin
        w_ptr_nxt = w_grant_inc;
      end else if (w_sel_last) begin
        w_ptr_nxt   = w_grant_inc;
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt   = ST_LOCKED;
        w_lock_id_nxt = w_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lock_id    <= '0;
      r_ptr        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_id     <= '0;
      r_beat_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_ptr     <= w_ptr_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_last  <= w_sel_last;
        r_out_id    <= w_grant;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid && bus.out_ready && (r_beat_count != 16'hFFFF)) begin
        r_beat_count <= r_beat_count + 16'd1;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_last   = r_out_last;
  assign bus.out_id     = r_out_id;
  assign bus.beat_count = r_beat_count;
endmodule
`default_nettype wire

// File: tb/tb_rr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_port_arbiter
// Purpose  : Drives a beat-mode and a packet-mode arbiter with identical
//            stimulus and checks both against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_rr_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  vin   = '1;
  logic [N-1:0]  vlast = '1;
  logic [N*DW-1:0] vdata = '0;
  logic          ordy  = 1'b1;

  int  total = 0;
  int  bad   = 0;
  bit  started = 1'b0;

  always #5 clk = ~clk;

  rr_port_arbiter_if #(.NUM_PORTS(N), .DATA_WIDTH(DW)) if0 ();
  rr_port_arbiter_if #(.NUM_PORTS(N), .DATA_WIDTH(DW)) if1 ();

  assign if0.in_valid = vin;   assign if1.in_valid = vin;
  assign if0.in_last  = vlast; assign if1.in_last  = vlast;
  assign if0.in_data  = vdata; assign if1.in_data  = vdata;
  assign if0.out_ready = ordy; assign if1.out_ready = ordy;

  rr_port_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .PACKET_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  rr_port_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .PACKET_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  // Model state per instance: index 0 = beat mode, 1 = packet mode.
  int       m_ptr[2];
  bit       m_lk[2];
  int       m_lkp[2];
  bit       m_ov[2];
  logic [7:0] m_od[2];
  bit       m_ol[2];
  int       m_oid[2];
  int       m_cnt[2];

  function automatic int pick(int m);
    if (m_lk[m]) return m_lkp[m];
    for (int j = 0; j < N; j++) begin
      if (vin[(m_ptr[m] + j) % N]) return (m_ptr[m] + j) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(int m);
    int g;
    g = pick(m);
    if (rst || g < 0 || !(!m_ov[m] || ordy)) return '0;
    return N'(1) << g;
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int g;
      bit le, drain;
      g     = pick(m);
      le    = !m_ov[m] || ordy;
      drain = m_ov[m] && ordy;
      if (rst) begin
        m_ptr[m] = 0; m_lk[m] = 0; m_lkp[m] = 0; m_ov[m] = 0;
        m_od[m] = 8'h00; m_ol[m] = 0; m_oid[m] = 0; m_cnt[m] = 0;
      end else begin
        if (drain && m_cnt[m] < 65535) m_cnt[m] = m_cnt[m] + 1;
        if (g >= 0 && le && vin[g]) begin
          m_ov[m]  = 1;
          m_od[m]  = vdata[g*DW +: DW];
          m_ol[m]  = vlast[g];
          m_oid[m] = g;
          if (m == 0 || vlast[g]) m_ptr[m] = (g + 1) % N;
          m_lk[m]  = (m == 1) && !vlast[g];
          m_lkp[m] = g;
        end else if (drain) begin
          m_ov[m] = 0;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(int m, logic [N-1:0] rdy, logic ov, logic [7:0] od,
                     logic ol, logic [1:0] oid, logic [15:0] cnt);
    chk($sformatf("m%0d in_ready", m), 32'(rdy), 32'(exp_ready(m)));
    chk($sformatf("m%0d out_valid", m), 32'(ov), 32'(m_ov[m]));
    chk($sformatf("m%0d beat_count", m), 32'(cnt), 32'(m_cnt[m]));
    if (m_ov[m]) begin
      chk($sformatf("m%0d out_data", m), 32'(od), 32'(m_od[m]));
      chk($sformatf("m%0d out_last", m), 32'(ol), 32'(m_ol[m]));
      chk($sformatf("m%0d out_id", m), 32'(oid), 32'(m_oid[m]));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (started) begin
      cmp(0, if0.in_ready, if0.out_valid, if0.out_data, if0.out_last, if0.out_id, if0.beat_count);
      cmp(1, if1.in_ready, if1.out_valid, if1.out_data, if1.out_last, if1.out_id, if1.beat_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic setd(int p, logic [7:0] v);
    vdata[p*DW +: DW] = v;
  endtask

  initial begin
    for (int p = 0; p < N; p++) setd(p, 8'(8'h10 * p));
    tick();
    started = 1'b1;
    tick();
    chk("rst out_valid", 32'(if0.out_valid), 32'h0);
    chk("rst in_ready", 32'(if0.in_ready), 32'h0);
    chk("rst beat_count", 32'(if1.beat_count), 32'h0);
    rst = 1'b0;
    #1;
    chk("first in_ready", 32'(if0.in_ready), 32'h1);

    // Beat-mode rotation with every port requesting.
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr id%0d", i), 32'(if0.out_id), 32'(i % 4));
    end
    chk("rr count", 32'(if0.beat_count), 32'd5);

    // Backpressure: hold A5 from port 2 while port 3 waits.
    vin = 4'b0100; setd(2, 8'hA5);
    tick();
    chk("bp load", 32'(if0.out_data), 32'hA5);
    ordy = 1'b0; vin = 4'b1000; setd(3, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp hold%0d", i), 32'(if0.out_data), 32'hA5);
      chk($sformatf("bp rdy%0d", i), 32'(if0.in_ready), 32'h0);
    end
    ordy = 1'b1;
    #1;
    chk("bp release rdy", 32'(if0.in_ready), 32'h8);
    tick();
    chk("bp next", 32'(if0.out_data), 32'h3C);
    chk("bp next valid", 32'(if0.out_valid), 32'h1);
    vin = 4'b0000;
    tick();
    chk("drain", 32'(if0.out_valid), 32'h0);

    // Packet lock: single beat from port 1 moves the pointer to 2.
    vin = 4'b0010; setd(1, 8'h11);
    tick();
    vin = 4'b0101; vlast = 4'b0001; setd(2, 8'h21); setd(0, 8'h0F);
    tick();
    chk("pkt b1 id", 32'(if1.out_id), 32'h2);
    vin = 4'b0001;
    #1;
    chk("pkt gap rdy", 32'(if1.in_ready), 32'h4);
    tick();
    chk("pkt gap stall", 32'(if1.out_valid), 32'h0);
    vin = 4'b0101; setd(2, 8'h22);
    tick();
    chk("pkt b2 id", 32'(if1.out_id), 32'h2);
    vlast = 4'b0101; setd(2, 8'h23);
    tick();
    chk("pkt b3 id", 32'(if1.out_id), 32'h2);
    chk("pkt b3 data", 32'(if1.out_data), 32'h23);
    vin = 4'b0001;
    tick();
    chk("pkt after id", 32'(if1.out_id), 32'h0);
    chk("pkt after data", 32'(if1.out_data), 32'h0F);

    // Reset in the middle of a port-1 packet.
    vin = 4'b0010; vlast = 4'b0000; setd(1, 8'h31);
    tick();
    chk("mid b1 id", 32'(if1.out_id), 32'h1);
    rst = 1'b1; vin = 4'b0011; vlast = 4'b0001;
    tick();
    chk("mid rst valid", 32'(if1.out_valid), 32'h0);
    rst = 1'b0;
    tick();
    chk("mid regrant id", 32'(if1.out_id), 32'h0);
    chk("mid regrant valid", 32'(if1.out_valid), 32'h1);

    // Saturation of the beat counter.
    vin = '1; vlast = '1; ordy = 1'b1;
    repeat (65540) tick();
    chk("sat m0", 32'(if0.beat_count), 32'hFFFF);
    chk("sat m1", 32'(if1.beat_count), 32'hFFFF);
    tick();
    chk("sat hold", 32'(if0.beat_count), 32'hFFFF);

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
